// File: rtl/term_pkg.sv
// Shared definitions for the character terminal controller: screen and VRAM
// geometry, controller state encoding and the control bytes it interprets.
package term_pkg;

    localparam int COLS_DEF  = 60;
    localparam int ROWS_DEF  = 17;

    // VRAM is a 64 x 32 character grid addressed as {row[4:0], col[5:0]}
    localparam int VRAM_COLS = 64;
    localparam int VRAM_ROWS = 32;
    localparam int COL_W     = 6;
    localparam int ROW_W     = 5;
    localparam int ADDR_W    = 11;

    typedef enum logic [1:0] {
        CLR_SCREEN = 2'd0,
        IDLE       = 2'd1,
        WRITE      = 2'd2,
        CLR_LINE   = 2'd3
    } state_t;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    // Everything from space upward except DEL lands in VRAM as a glyph
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CH_SPACE) && (b != CH_DEL);
    endfunction

endpackage

// File: rtl/term_ctrl.sv
// Character terminal controller: takes a byte stream, writes glyphs into VRAM,
// interprets CR/LF/BS/TAB/FF and clears lines/screen on scroll or form feed.
module term_ctrl
    import term_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [7:0]        o_vram_data,
    output logic              o_vram_ce
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t            state_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ADDR_W-1:0] cnt_reg;

    logic [ROW_W-1:0]  row_adv;
    logic [COL_W-1:0]  col_inc;
    logic [COL_W:0]    tab_sum;
    logic [COL_W-1:0]  tab_col;
    logic [COL_W-1:0]  bs_col;
    logic              accept;

    always_comb begin
        row_adv = (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
        col_inc = col_reg + 1'b1;
        // One extra bit so a tab from the last tab stop can exceed the row and be clamped
        tab_sum = {1'b0, col_reg | COL_W'(7)} + (COL_W+1)'(1);
        tab_col = (tab_sum > {1'b0, LAST_COL}) ? LAST_COL : tab_sum[COL_W-1:0];
        bs_col  = (col_reg == '0) ? col_reg : col_reg - 1'b1;
    end

    assign accept = i_rx_valid & o_rx_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= CLR_SCREEN;
            row_reg     <= '0;
            col_reg     <= '0;
            cnt_reg     <= '0;
            o_vram_addr <= '0;
            o_vram_data <= CH_SPACE;
            o_vram_ce   <= 1'b0;
            o_rx_ready  <= 1'b0;
        end else begin
            case (state_reg)
                // cnt_reg is the next address to clear; done once 0x7FF has been written
                CLR_SCREEN: begin
                    if (o_vram_ce && (o_vram_addr == '1)) begin
                        state_reg   <= IDLE;
                        o_vram_ce   <= 1'b0;
                        o_vram_addr <= {row_reg, col_reg};
                        o_rx_ready  <= 1'b1;
                    end else begin
                        o_vram_ce   <= 1'b1;
                        o_vram_addr <= cnt_reg;
                        o_vram_data <= CH_SPACE;
                        cnt_reg     <= cnt_reg + 1'b1;
                    end
                end

                IDLE: begin
                    if (accept) begin
                        if (is_printable(i_rx_data)) begin
                            state_reg   <= WRITE;
                            o_rx_ready  <= 1'b0;
                            o_vram_ce   <= 1'b1;
                            o_vram_addr <= {row_reg, col_reg};
                            o_vram_data <= i_rx_data;
                        end else begin
                            case (i_rx_data)
                                CH_CR: begin
                                    col_reg     <= '0;
                                    o_vram_addr <= {row_reg, COL_W'(0)};
                                end
                                CH_LF: begin
                                    // First clear cycle is issued right away so the line clear is gap-free
                                    row_reg     <= row_adv;
                                    state_reg   <= CLR_LINE;
                                    o_rx_ready  <= 1'b0;
                                    o_vram_ce   <= 1'b1;
                                    o_vram_addr <= {row_adv, COL_W'(0)};
                                    o_vram_data <= CH_SPACE;
                                    cnt_reg     <= ADDR_W'(1);
                                end
                                CH_BS: begin
                                    col_reg     <= bs_col;
                                    o_vram_addr <= {row_reg, bs_col};
                                end
                                CH_TAB: begin
                                    col_reg     <= tab_col;
                                    o_vram_addr <= {row_reg, tab_col};
                                end
                                CH_FF: begin
                                    row_reg     <= '0;
                                    col_reg     <= '0;
                                    state_reg   <= CLR_SCREEN;
                                    o_rx_ready  <= 1'b0;
                                    o_vram_ce   <= 1'b1;
                                    o_vram_addr <= '0;
                                    o_vram_data <= CH_SPACE;
                                    cnt_reg     <= ADDR_W'(1);
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                WRITE: begin
                    if (col_reg == LAST_COL) begin
                        col_reg     <= '0;
                        row_reg     <= row_adv;
                        state_reg   <= CLR_LINE;
                        o_vram_ce   <= 1'b1;
                        o_vram_addr <= {row_adv, COL_W'(0)};
                        o_vram_data <= CH_SPACE;
                        cnt_reg     <= ADDR_W'(1);
                    end else begin
                        col_reg     <= col_inc;
                        state_reg   <= IDLE;
                        o_vram_ce   <= 1'b0;
                        o_rx_ready  <= 1'b1;
                        o_vram_addr <= {row_reg, col_inc};
                    end
                end

                // Clears all 64 VRAM columns of the row, including the invisible ones
                CLR_LINE: begin
                    if (o_vram_addr[COL_W-1:0] == '1) begin
                        state_reg   <= IDLE;
                        o_vram_ce   <= 1'b0;
                        o_vram_addr <= {row_reg, col_reg};
                        o_rx_ready  <= 1'b1;
                    end else begin
                        o_vram_ce   <= 1'b1;
                        o_vram_addr <= {row_reg, cnt_reg[COL_W-1:0]};
                        o_vram_data <= CH_SPACE;
                        cnt_reg     <= cnt_reg + 1'b1;
                    end
                end

                default: state_reg <= CLR_SCREEN;
            endcase
        end
    end

endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: transaction-level cursor model with an expected-write
// queue, checked every cycle, plus literal checks on known cursor positions.
module tb_term_ctrl;

    localparam int COLS = 60;
    localparam int ROWS = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [10:0] vram_addr;
    logic [7:0]  vram_data;
    logic        vram_ce;

    always #5 clk = ~clk;

    term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .o_vram_addr (vram_addr),
        .o_vram_data (vram_data),
        .o_vram_ce   (vram_ce)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur_row  = 0;
    int          cur_col  = 0;
    int          exp_q[$];          // expected writes, addr*256 + data
    logic        chk_en   = 1'b0;
    logic [7:0]  last_data = 8'h20;
    logic [10:0] last_wr_addr = '0;
    logic [7:0]  last_wr_data = '0;
    int          cmp_e;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every cycle: writes must match the expected queue, data must hold between writes
    always @(negedge clk) begin
        if (chk_en) begin
            if (vram_ce === 1'b1) begin
                last_wr_addr = vram_addr;
                last_wr_data = vram_data;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", vram_addr, vram_data);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("write_addr", 32'(vram_addr), 32'(cmp_e >> 8));
                    check("write_data", 32'(vram_data), 32'(cmp_e & 255));
                    last_data = 8'(cmp_e & 255);
                end
                check("ready_while_writing", 32'(rx_ready), 32'd0);
            end else begin
                check("data_hold", 32'(vram_data), 32'(last_data));
            end
        end
    end

    function automatic int next_row(input int r);
        return (r == ROWS - 1) ? 0 : r + 1;
    endfunction

    task automatic row_advance();
        cur_row = next_row(cur_row);
        for (int i = 0; i < 64; i++) exp_q.push_back((cur_row * 64 + i) * 256 + 32'h20);
    endtask

    task automatic release_and_clear();
        int m;
        cur_row = 0;
        cur_col = 0;
        exp_q.delete();
        last_data = 8'h20;
        for (int i = 0; i < 2048; i++) exp_q.push_back(i * 256 + 32'h20);
        rst = 1'b0;
        chk_en = 1'b1;
        m = 0;
        while (rx_ready !== 1'b1 && m < 5000) begin
            @(negedge clk);
            m++;
        end
        $display("txn reset-release clear latency=%0d", m);
        check("clear_latency", 32'(m), 32'd2049);
        check("clear_idle_addr", 32'(vram_addr), 32'd0);
        check("clear_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        int m;
        int lat_exp;
        m = 0;
        while (rx_ready !== 1'b1 && m < 5000) begin
            @(negedge clk);
            m++;
        end
        lat_exp = 1;
        if (b >= 8'h20 && b != 8'h7F) begin
            exp_q.push_back((cur_row * 64 + cur_col) * 256 + int'(b));
            cur_col++;
            lat_exp = 2;
            if (cur_col == COLS) begin
                cur_col = 0;
                row_advance();
                lat_exp = 66;
            end
        end else begin
            case (b)
                8'h0D: cur_col = 0;
                8'h0A: begin
                    row_advance();
                    lat_exp = 65;
                end
                8'h08: if (cur_col > 0) cur_col--;
                8'h09: begin
                    cur_col = (cur_col | 7) + 1;
                    if (cur_col > COLS - 1) cur_col = COLS - 1;
                end
                8'h0C: begin
                    cur_row = 0;
                    cur_col = 0;
                    for (int i = 0; i < 2048; i++) exp_q.push_back(i * 256 + 32'h20);
                    lat_exp = 2049;
                end
                default: ;
            endcase
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        m = 1;
        rx_valid = 1'b0;
        // Junk offered while busy must be ignored
        while (rx_ready !== 1'b1 && m < 3000) begin
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_data  = 8'($urandom);
            @(negedge clk);
            m++;
        end
        rx_valid = 1'b0;
        $display("txn byte=0x%02h cursor=(%0d,%0d) latency=%0d", b, cur_row, cur_col, m);
        check("latency", 32'(m), 32'(lat_exp));
        check("idle_addr", 32'(vram_addr), 32'(cur_row * 64 + cur_col));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        int nr;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ce", 32'(vram_ce), 32'd0);
        check("rst_addr", 32'(vram_addr), 32'd0);
        check("rst_data", 32'(vram_data), 32'h20);
        check("rst_ready", 32'(rx_ready), 32'd0);
        release_and_clear();

        send(8'h41);
        check("A_wr_addr", 32'(last_wr_addr), 32'h000);
        check("A_wr_data", 32'(last_wr_data), 32'h41);
        check("A_idle_addr", 32'(vram_addr), 32'h001);
        send(8'h0D);
        check("CR_addr", 32'(vram_addr), 32'h000);

        repeat (5) send(8'h0A);
        repeat (8) send(8'h09);
        check("pos_5_59", 32'(vram_addr), 32'h17B);
        send(8'h5A);
        check("Z_last_clear", 32'(last_wr_addr), 32'h1BF);
        check("Z_idle_addr", 32'(vram_addr), 32'h180);

        repeat (10) send(8'h0A);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        check("pos_16_3", 32'(vram_addr), 32'h403);
        send(8'h0A);
        check("LF_wrap_last_clear", 32'(last_wr_addr), 32'h03F);
        check("LF_wrap_addr", 32'(vram_addr), 32'h003);
        send(8'h0D);
        check("CR_row0", 32'(vram_addr), 32'h000);

        send(8'h0A);
        send(8'h0A);
        send(8'h08);
        check("BS_col0", 32'(vram_addr), 32'h080);
        send(8'h09);
        check("TAB_col8", 32'(vram_addr), 32'h088);
        repeat (6) send(8'h09);
        send(8'h71);
        check("pos_2_57", 32'(vram_addr), 32'h0B9);
        send(8'h09);
        check("TAB_clamp", 32'(vram_addr), 32'h0BB);
        send(8'h07);
        check("BEL_ignored", 32'(vram_addr), 32'h0BB);
        send(8'h7F);
        check("DEL_ignored", 32'(vram_addr), 32'h0BB);
        send(8'h0C);
        check("FF_addr", 32'(vram_addr), 32'h000);

        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                b = 8'($urandom_range(32, 255));
                if (b == 8'h7F) b = 8'h80;
            end else if (r < 58) b = 8'h0A;
            else if (r < 68) b = 8'h0D;
            else if (r < 76) b = 8'h08;
            else if (r < 88) b = 8'h09;
            else if (r < 96) b = 8'($urandom_range(0, 31));
            else if (r < 98) b = 8'h7F;
            else b = 8'h0C;
            send(b);
        end

        // Reset in the middle of a line clear
        chk_en = 1'b0;
        nr = next_row(cur_row);
        rx_data  = 8'h0A;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (9) @(negedge clk);
        $display("txn byte=0x0a interrupted by reset");
        check("mid_clear_ce", 32'(vram_ce), 32'd1);
        check("mid_clear_addr", 32'(vram_addr), 32'(nr * 64 + 9));
        #2 rst = 1'b1;
        #1;
        check("async_rst_ce", 32'(vram_ce), 32'd0);
        check("async_rst_addr", 32'(vram_addr), 32'd0);
        check("async_rst_data", 32'(vram_data), 32'h20);
        check("async_rst_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("held_rst_ce", 32'(vram_ce), 32'd0);
        release_and_clear();

        send(8'h41);
        check("post_rst_wr_addr", 32'(last_wr_addr), 32'h000);
        check("post_rst_addr", 32'(vram_addr), 32'h001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/term_ctrl.md
TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 Parameter COLS, default 60: visible columns per row.
REQ-002 Parameter ROWS, default 17: visible rows.
REQ-003 i_clk  input  1  system clock (24 MHz); the block's only clock.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_rx_data  input  8  incoming character byte.
REQ-006 i_rx_valid  input  1  i_rx_data valid.
REQ-007 o_rx_ready  output  1  block can accept a byte; transfer occurs on a rising edge with i_rx_valid & o_rx_ready.
REQ-008 o_vram_addr  output  11  VRAM write address {row[4:0], col[5:0]}; when idle it holds the cursor position, which is used for cursor display.
REQ-009 o_vram_data  output  8  VRAM write data.
REQ-010 o_vram_ce  output  1  VRAM write enable, one write per cycle while high.

Function
REQ-011 All outputs SHALL be registered; states: CLR_SCREEN, IDLE, WRITE, CLR_LINE.
REQ-012 o_rx_ready SHALL be 1 only in IDLE; i_rx_valid is ignored in every other state.
REQ-013 Printable byte (0x20-0x7E, 0x80-0xFF) accepted at edge k: cycle k+1 in WRITE with o_vram_ce=1, o_vram_addr=cursor, o_vram_data=byte; edge k+2 advances cursor and returns to IDLE (ce=0).
REQ-014 Cursor advance: col+1; if the new col equals COLS, col=0 and a row advance follows.
REQ-015 Row advance: row = (row==ROWS-1) ? 0 : row+1, then CLR_LINE for the new row.
REQ-016 CLR_LINE SHALL last exactly 64 cycles with ce=1, data=0x20, addr={row, 0..63} ascending, then enter IDLE with addr=cursor.
REQ-017 0x0D (CR): col=0, no write, stays IDLE; ready is high again on the next cycle.
REQ-018 0x0A (LF): col unchanged, row advance per REQ-015.
REQ-019 0x08 (BS): col-1 if col>0, else no change; no write.
REQ-020 0x09 (TAB): col = (col|7)+1, clamped to COLS-1; no write; never wraps the row.
REQ-021 0x0C (FF): cursor to (0,0), enter CLR_SCREEN.
REQ-022 CLR_SCREEN SHALL last exactly 2048 cycles with ce=1, data=0x20, addr 0..2047 ascending, then enter IDLE with addr=0.
REQ-023 Other bytes (0x00-0x1F not listed above, and 0x7F) SHALL be accepted and dropped, with no state or cursor change.
REQ-024 Cursor invariant: col<COLS and row<ROWS at all times.
REQ-025 o_vram_data SHALL hold its last value when ce=0.

Reset
REQ-026 Asserting i_rst in any state SHALL immediately set: state=CLR_SCREEN, cursor=(0,0), clear counter=0, o_vram_addr=0, o_vram_data=0x20, o_vram_ce=0, o_rx_ready=0.
REQ-027 On the first edge after reset release, the full REQ-022 clear SHALL begin; a reset during a clear aborts it and restarts the clear from address 0.

Structure
REQ-028 Shared package term_pkg SHALL hold: COLS/ROWS defaults, VRAM geometry (64x32, 11-bit address), state encoding, control codes (CR, LF, BS, TAB, FF, SPACE).
REQ-029 The design SHALL be a single module with no sub-module; one 11-bit counter is shared by CLR_LINE (low 6 bits) and CLR_SCREEN.

Verification
REQ-030 Reset release -> 2048 consecutive ce cycles, addr 0..2047, data 0x20; then ready=1, addr=0.
REQ-031 Send 'A' (0x41) at (0,0) -> one ce cycle addr=0x000 data=0x41; next idle addr=0x001.
REQ-032 Cursor (5,59), send 'Z' -> write at 0x17B; then 64-cycle clear of row 6 (0x180-0x1BF); final addr 0x180.
REQ-033 Cursor (16,3), send LF -> clear of row 0 (0x000-0x03F); final addr 0x003; then CR -> addr 0x000.
REQ-034 Cursor (2,0): BS -> addr unchanged 0x080; TAB -> 0x088; with col 57, TAB -> col 59; 0x07 -> no change.
REQ-035 Assert i_rst mid CLR_LINE -> ce=0 immediately, all outputs at reset values; after release, full-screen clear restarts at addr 0.
